// File: rtl/load_pkg.sv
// Shared definitions for the load path.
//   F3_*          : legal funct3 load encodings
//   load_state_e  : load_unit FSM states
//   is_legal()    : funct3 names a supported load
//   is_split()    : access spans two aligned words
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StResp
  } load_state_e;

  function automatic logic is_legal(input logic [2:0] f3);
    logic legal;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Byte loads never split; halfwords only at lane 3; words at any non-zero lane.
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    logic split;
    case (f3)
      F3_LH, F3_LHU: split = (off == 2'd3);
      F3_LW:         split = (off != 2'd0);
      default:       split = 1'b0;
    endcase
    return split;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Word-addressed data memory read bus.
//   MemAddr  : word-aligned read address (bits [1:0] = 00)
//   MemRead  : read strobe, held with MemAddr stable until MemValid
//   MemValid : ReadData valid this cycle
//   ReadData : memory word
// master = requester (load_unit), slave = memory.
interface load_unit_if;

  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemValid;
  logic [31:0] ReadData;

  modport master (
    output MemAddr,
    output MemRead,
    input  MemValid,
    input  ReadData
  );

  modport slave (
    input  MemAddr,
    input  MemRead,
    output MemValid,
    output ReadData
  );

endinterface

// File: rtl/load_align.sv
// Combinational load alignment and extension.
//   word0    : lower aligned word (holds the addressed byte lane)
//   word1    : next aligned word, 0 when the access does not split
//   off      : byte lane of the address, little-endian
//   funct3   : load type
//   LoadData : selected byte/halfword/word, sign- or zero-extended; 0 for illegal types
module load_align
  import load_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] LoadData
);

  // Low 32 bits of {word1, word0} >> (8 * off).
  logic [31:0] shifted;

  // The top byte of word1 can never reach the low 32 bits of the shifted window.
  logic unused_word1_hi;
  assign unused_word1_hi = ^word1[31:24];

  always_comb begin
    shifted = word0;
    case (off)
      2'd0: shifted = word0;
      2'd1: shifted = {word1[7:0],  word0[31:8]};
      2'd2: shifted = {word1[15:0], word0[31:16]};
      2'd3: shifted = {word1[23:0], word0[31:24]};
      default: shifted = word0;
    endcase
  end

  always_comb begin
    LoadData = 32'h0;
    case (funct3)
      F3_LB:   LoadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   LoadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   LoadData = shifted;
      F3_LBU:  LoadData = {24'h0, shifted[7:0]};
      F3_LHU:  LoadData = {16'h0, shifted[15:0]};
      default: LoadData = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: one request at a time, one or two aligned word reads,
// then byte/halfword/word selection with extension and a one-cycle response pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : load request present
//   req_ready   : idle; request accepted on req_valid & req_ready
//   Addr        : byte address, sampled on accept
//   funct3      : load type, sampled on accept
//   mem         : memory read bus (master side)
//   resp_valid  : one-cycle response pulse
//   LoadData    : extended result, held until the next response
//   load_error  : LoadData came from an illegal funct3
module load_unit
  import load_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        Addr,
  input  logic [2:0]         funct3,
  load_unit_if.master        mem,
  output logic               resp_valid,
  output logic [31:0]        LoadData,
  output logic               load_error
);

  load_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;
  logic [31:0] load_data_q;
  logic        load_error_q;

  logic        accept;
  logic        split;
  logic [31:0] word0_addr;
  logic [31:0] align_w0;
  logic [31:0] align_w1;
  logic [31:0] align_data;

  assign accept     = (state_q == StIdle) && req_valid;
  assign split      = is_split(funct3_q, addr_q[1:0]);
  assign word0_addr = {addr_q[31:2], 2'b00};

  // The final word is taken live from ReadData so the result can be registered
  // on the same edge that enters StResp.
  assign align_w0 = (state_q == StRd1) ? word0_q      : mem.ReadData;
  assign align_w1 = (state_q == StRd1) ? mem.ReadData : word1_q;

  load_align u_align (
    .word0    (align_w0),
    .word1    (align_w1),
    .off      (addr_q[1:0]),
    .funct3   (funct3_q),
    .LoadData (align_data)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = is_legal(funct3) ? StRd0 : StResp;
        end
      end
      StRd0: begin
        if (mem.MemValid) begin
          state_d = split ? StRd1 : StResp;
        end
      end
      StRd1: begin
        if (mem.MemValid) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state and latched address only.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem.MemRead = 1'b0;
    mem.MemAddr = 32'h0;
    case (state_q)
      StIdle: req_ready = 1'b1;
      StRd0: begin
        mem.MemRead = 1'b1;
        mem.MemAddr = word0_addr;
      end
      StRd1: begin
        mem.MemRead = 1'b1;
        mem.MemAddr = word0_addr + 32'd4;  // wraps past 0xFFFFFFFC
      end
      StResp:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= 32'h0;
      funct3_q     <= 3'b000;
      word0_q      <= 32'h0;
      word1_q      <= 32'h0;
      load_data_q  <= 32'h0;
      load_error_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= Addr;
        funct3_q <= funct3;
        // Cleared so an unsplit access sees an all-zero upper window word.
        word1_q  <= 32'h0;
        if (!is_legal(funct3)) begin
          load_data_q  <= 32'h0;
          load_error_q <= 1'b1;
        end
      end
      if ((state_q == StRd0) && mem.MemValid) begin
        word0_q <= mem.ReadData;
        if (!split) begin
          load_data_q  <= align_data;
          load_error_q <= 1'b0;
        end
      end
      if ((state_q == StRd1) && mem.MemValid) begin
        word1_q      <= mem.ReadData;
        load_data_q  <= align_data;
        load_error_q <= 1'b0;
      end
    end
  end

  assign LoadData   = load_data_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  import load_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] Addr;
  logic [2:0]  funct3;
  logic        resp_valid;
  logic [31:0] LoadData;
  logic        load_error;

  load_unit_if mem_bus ();

  load_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .Addr       (Addr),
    .funct3     (funct3),
    .mem        (mem_bus),
    .resp_valid (resp_valid),
    .LoadData   (LoadData),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model state.
  logic [31:0] m_addr [8];
  logic [31:0] m_data [8];
  logic [31:0] rd_log [4];
  int          n_logged;
  int          waits0;
  int          waits1;
  int          rd_idx;
  int          rd_cycles;
  int          wait_cnt;
  int          addr_unstable;
  logic [31:0] prev_addr;
  logic        prev_rd;

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    for (int i = 0; i < 8; i++) begin
      if (m_addr[i] == a) return m_data[i];
    end
    return 32'hDEAD_BEEF;
  endfunction

  // Memory responder: drives MemValid/ReadData on the falling edge.
  initial begin
    logic pv;
    int   target;
    mem_bus.MemValid = 1'b0;
    mem_bus.ReadData = 32'h0;
    wait_cnt = 0;
    prev_rd  = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      pv = mem_bus.MemValid;
      if (pv) wait_cnt = 0;
      if (!mem_bus.MemRead) begin
        mem_bus.MemValid = 1'b0;
        wait_cnt = 0;
        prev_rd  = 1'b0;
      end else begin
        rd_cycles++;
        if (prev_rd && !pv && (mem_bus.MemAddr != prev_addr)) addr_unstable++;
        target = (rd_idx == 0) ? waits0 : waits1;
        if (wait_cnt >= target) begin
          mem_bus.MemValid = 1'b1;
          mem_bus.ReadData = mem_lookup(mem_bus.MemAddr);
          if (n_logged < 4) rd_log[n_logged] = mem_bus.MemAddr;
          n_logged++;
          rd_idx++;
        end else begin
          mem_bus.MemValid = 1'b0;
          mem_bus.ReadData = 32'h0;
          wait_cnt++;
        end
        prev_addr = mem_bus.MemAddr;
        prev_rd   = 1'b1;
      end
    end
  end

  task automatic start_req(input logic [31:0] a, input logic [2:0] f3, input int w0,
                           input int w1);
    @(negedge clk);
    waits0 = w0;
    waits1 = w1;
    rd_idx = 0;
    rd_cycles = 0;
    addr_unstable = 0;
    n_logged = 0;
    req_valid = 1'b1;
    Addr = a;
    funct3 = f3;
    @(negedge clk);
    // Scrambled after accept; must have no effect.
    req_valid = 1'b0;
    Addr = 32'h5A5A_5A5A;
    funct3 = 3'b011;
  endtask

  // Latency counts the accept cycle as 0; returns -1 on timeout.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input int w0,
                          input int w1, output int lat);
    start_req(a, f3, w0, w1);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (resp_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Extra directed vectors against mem[0x1000]=0x80FF1234, mem[0x1004]=0xDEADBEEF.
  logic [31:0] v_addr [5];
  logic [2:0]  v_f3   [5];
  logic [31:0] v_exp  [5];
  int          v_lat  [5];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic found;
    logic seen;

    rst_n = 1'b0;
    req_valid = 1'b0;
    Addr = 32'h0;
    funct3 = 3'b000;
    waits0 = 0;
    waits1 = 0;
    rd_idx = 0;
    rd_cycles = 0;
    n_logged = 0;
    addr_unstable = 0;

    m_addr[0] = 32'h0000_1000; m_data[0] = 32'h80FF_1234;
    m_addr[1] = 32'h0000_2000; m_data[1] = 32'hAB00_0000;
    m_addr[2] = 32'h0000_2004; m_data[2] = 32'h0000_00CD;
    m_addr[3] = 32'hFFFF_FFFC; m_data[3] = 32'h1122_3344;
    m_addr[4] = 32'h0000_0000; m_data[4] = 32'h5566_7788;
    m_addr[5] = 32'h0000_0040; m_data[5] = 32'h0000_8001;
    m_addr[6] = 32'h0000_0100; m_data[6] = 32'h0101_0101;
    m_addr[7] = 32'h0000_0104; m_data[7] = 32'h0202_0202;

    v_addr[0] = 32'h1001; v_f3[0] = F3_LBU; v_exp[0] = 32'h0000_0012; v_lat[0] = 2;
    v_addr[1] = 32'h1002; v_f3[1] = F3_LHU; v_exp[1] = 32'h0000_80FF; v_lat[1] = 2;
    v_addr[2] = 32'h1001; v_f3[2] = F3_LH;  v_exp[2] = 32'hFFFF_FF12; v_lat[2] = 2;
    v_addr[3] = 32'h1000; v_f3[3] = F3_LW;  v_exp[3] = 32'h80FF_1234; v_lat[3] = 2;
    v_addr[4] = 32'h1001; v_f3[4] = F3_LW;  v_exp[4] = 32'hEF80_FF12; v_lat[4] = 3;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", 32'(resp_valid), 32'd0);
    check("rst_memread", 32'(mem_bus.MemRead), 32'd0);
    check("rst_memaddr", mem_bus.MemAddr, 32'h0);
    check("rst_data", LoadData, 32'h0);
    check("rst_err", 32'(load_error), 32'd0);
    rst_n = 1'b1;

    // LB, lane 3, no wait states.
    run_load(32'h0000_1003, F3_LB, 0, 0, lat);
    check("lb_lat", lat, 2);
    check("lb_data", LoadData, 32'hFFFF_FF80);
    check("lb_err", 32'(load_error), 32'd0);
    check("lb_reads", rd_cycles, 1);
    check("lb_addr", rd_log[0], 32'h0000_1000);

    // LHU split across 0x2000/0x2004.
    run_load(32'h0000_2003, F3_LHU, 0, 0, lat);
    check("lhu_lat", lat, 3);
    check("lhu_addr0", rd_log[0], 32'h0000_2000);
    check("lhu_addr1", rd_log[1], 32'h0000_2004);
    check("lhu_data", LoadData, 32'h0000_CDAB);

    // LW wrapping the top of the address space.
    run_load(32'hFFFF_FFFE, F3_LW, 0, 0, lat);
    check("lw_wrap_lat", lat, 3);
    check("lw_wrap_addr0", rd_log[0], 32'hFFFF_FFFC);
    check("lw_wrap_addr1", rd_log[1], 32'h0000_0000);
    check("lw_wrap_data", LoadData, 32'h7788_1122);

    // LH with four wait states.
    run_load(32'h0000_0040, F3_LH, 4, 0, lat);
    check("lh_wait_lat", lat, 6);
    check("lh_wait_cycles", rd_cycles, 5);
    check("lh_wait_stable", addr_unstable, 0);
    check("lh_wait_data", LoadData, 32'hFFFF_8001);

    for (int i = 0; i < 5; i++) begin
      run_load(v_addr[i], v_f3[i], 0, 0, lat);
      check($sformatf("vec%0d_lat", i), lat, v_lat[i]);
      check($sformatf("vec%0d_data", i), LoadData, v_exp[i]);
      check($sformatf("vec%0d_err", i), 32'(load_error), 32'd0);
    end

    // Illegal funct3 with req_valid held through the response.
    @(negedge clk);
    rd_cycles = 0;
    req_valid = 1'b1;
    Addr = 32'h0000_3000;
    funct3 = 3'b011;
    @(negedge clk);
    check("ill_resp", 32'(resp_valid), 32'd1);
    check("ill_err", 32'(load_error), 32'd1);
    check("ill_data", LoadData, 32'h0);
    check("ill_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ill_no_reaccept", {29'h0, resp_valid, req_ready, mem_bus.MemRead}, 32'b010);
    check("ill_no_read", rd_cycles, 0);
    req_valid = 1'b0;

    // Reset while stalled in the second read.
    start_req(32'h0000_0101, F3_LW, 0, 50);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (mem_bus.MemRead && (mem_bus.MemAddr == 32'h0000_0104)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_reach_rd1", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_memread", 32'(mem_bus.MemRead), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_memaddr", mem_bus.MemAddr, 32'h0);
    check("rst_mid_data", LoadData, 32'h0);
    check("rst_mid_err", 32'(load_error), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);

    m_data[4] = 32'hCAFE_F00D;
    run_load(32'h0000_0000, F3_LW, 0, 0, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", LoadData, 32'hCAFE_F00D);
    check("post_rst_addr", rd_log[0], 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
